pixel_fetch: RTL and testbench
==============================

Name: pixel_fetch

Overview:
- Frame fetch engine on a RAM client port (adr/req/ack/write/sel/rdata/wdata, 18-bit word address, 16-bit data).
- On a start pulse it reads NUM_PIXELS pixels from SRAM and buffers them in a small FIFO.
- It presents them as 24-bit GRB words on a valid/ready stream to the WS2812 serializer.
- Sits between ram port c and the lights output stage.

Parameters:
- BASE_ADR, 18'h0, word address of pixel 0 in SRAM.
- NUM_PIXELS, 60, pixels per frame (1..1023).
- FIFO_DEPTH, 4, pixel FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse: begin fetching a frame
- busy  output  1  high while a frame is being fetched
- frame_done  output  1  one-cycle pulse when the last pixel is pushed into the FIFO
- m_adr  output  18  RAM word address
- m_req  output  1  RAM request
- m_ack  input  1  RAM acknowledge; m_rdata valid in this cycle
- m_write  output  1  always 0
- m_sel  output  2  always 2'b11
- m_rdata  input  16  RAM read data
- m_wdata  output  16  always 0
- pix_data  output  24  {G,R,B}
- pix_valid  output  1  FIFO not empty
- pix_ready  input  1  consumer accepts pix_data when pix_valid && pix_ready

Behaviour:
- Reset: all outputs 0 except m_sel=2'b11. FIFO emptied, state IDLE, pixel index 0.
- Pixel layout: pixel i occupies two words.
  - Word BASE_ADR+2i: [15:8]=G, [7:0]=R.
  - Word BASE_ADR+2i+1: [7:0]=B; [15:8] ignored.
- Address arithmetic is mod 2^18; wrap past 18'h3FFFF is allowed and not flagged.
- RAM handshake:
  - m_req is held high with m_adr stable until m_ack is sampled high.
  - m_req drops in the cycle after ack (registered).
  - Only one request is outstanding at a time.
  - m_ack while m_req is low is ignored.
- FSM states: IDLE, RD_LO, RD_HI, PUSH.
  - IDLE: busy=0. start → index=0, go to RD_LO. start while not IDLE is ignored.
  - RD_LO: assert m_req at address BASE+2*index only when the FIFO count < FIFO_DEPTH; otherwise wait with m_req low. On ack, latch G,R and go to RD_HI.
  - RD_HI: m_req at BASE+2*index+1. On ack, latch B and go to PUSH.
  - PUSH: write {G,R,B} into the FIFO; space is guaranteed because it was checked in RD_LO and this block is the only writer.
    - If index==NUM_PIXELS-1: pulse frame_done and go to IDLE.
    - Else: index+1, go to RD_LO.
- Latency, no stalls, one-cycle ack: start→first m_req = 1 cycle; ack(RD_HI)→pix_valid = 2 cycles (PUSH, then FIFO registered output).
- FIFO:
  - Synchronous, first-word-fall-through.
  - pix_data is stable while pix_valid && !pix_ready.
  - Simultaneous push and pop at any count (including full) is legal; count is unchanged.
  - Pop on empty has no effect.
- busy = (state != IDLE). The FIFO may still hold pixels after busy falls; a new start is accepted immediately and appends behind them.
- Reset mid-frame:
  - State, FIFO and index are cleared next edge; m_req falls.
  - A late m_ack from the abandoned access is ignored.

Decomposition:
- Shared package lights_pkg:
  - typedef pixel_t (24-bit packed struct g,r,b).
  - enum fetch_state_t {IDLE, RD_LO, RD_HI, PUSH}.
  - Constants PIX_WORDS=2 and SEL_WORD=2'b11.
- One sub-module: pixel_fifo (parameter DEPTH, pixel_t in/out, push/pop, count, full, empty), reusable by the serializer.

Test Plan:
- NUM_PIXELS=2, BASE=18'h100, RAM has 0x100=16'h1122, 0x101=16'hAB33, 0x102=16'h4455, 0x103=16'h0066, one-cycle ack, pix_ready=1 → m_adr sequence 100,101,102,103; pix_data 24'h112233 then 24'h445566; one frame_done pulse; busy falls.
- Same setup, ack delayed 5 cycles per access → m_req and m_adr held stable for 5 cycles each; same pixel output.
- pix_ready=0, NUM_PIXELS=8, FIFO_DEPTH=4 → exactly 4 pixels fetched (8 reads), then m_req stays low. Raise pix_ready → remaining 4 pixels fetched; output order preserved.
- start pulsed again during a frame → ignored; only NUM_PIXELS pixels produced.
- rst asserted while m_req high in RD_HI → next cycle m_req=0, pix_valid=0, busy=0. Stray m_ack afterwards → no FIFO push, no state change.
- BASE=18'h3FFFE, NUM_PIXELS=2 → addresses 3FFFE, 3FFFF, 00000, 00001.

Source files
------------

// File: rtl/lights_pkg.sv
// lights_pkg: shared pixel type, fetch FSM states and RAM port constants for the lights path
package lights_pkg;
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;
  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, PUSH} fetch_state_t;
  localparam int PIX_WORDS = 2;
  localparam logic [1:0] SEL_WORD = 2'b11;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: first-word-fall-through pixel FIFO; push/pop in, dout/count/full/empty out
module pixel_fifo
  import lights_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  pixel_t                   din,
  input  logic                     pop,
  output pixel_t                   dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  pixel_t mem_q [DEPTH];
  pixel_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full  = count_q == CW'(DEPTH);
  assign count = count_q;
  // Zero while empty so the stream bus idles at 0 rather than stale data.
  assign dout  = empty ? '0 : mem_q[rd_q];
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/pixel_fetch.sv
// pixel_fetch: reads NUM_PIXELS two-word pixels from SRAM on start and streams them as {G,R,B}
module pixel_fetch
  import lights_pkg::*;
#(
  parameter logic [17:0] BASE_ADR   = 18'h0,
  parameter int          NUM_PIXELS = 60,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [17:0] m_adr,
  output logic        m_req,
  input  logic        m_ack,
  output logic        m_write,
  output logic [1:0]  m_sel,
  input  logic [15:0] m_rdata,
  output logic [15:0] m_wdata,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [9:0] idx_q, idx_d;
  pixel_t pix_q, pix_d, fifo_out;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty, push;
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pix_d      = pix_q;
    m_req      = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        // Reserve a FIFO slot before fetching so PUSH never meets a full FIFO.
        m_req = fifo_count < CW'(FIFO_DEPTH);
        if (m_req && m_ack) begin
          pix_d.g = m_rdata[15:8];
          pix_d.r = m_rdata[7:0];
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        m_req = 1'b1;
        if (m_ack) begin
          pix_d.b = m_rdata[7:0];
          state_d = PUSH;
        end
      end
      default: begin
        frame_done = idx_q == 10'(NUM_PIXELS - 1);
        state_d    = frame_done ? IDLE : RD_LO;
        idx_d      = frame_done ? idx_q : idx_q + 10'd1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
    end
  end
  // Address wraps mod 2^18 by width; held at 0 whenever no request is out.
  assign m_adr     = m_req ? BASE_ADR + 18'(idx_q) * 18'(PIX_WORDS) + 18'(state_q == RD_HI) : '0;
  assign m_write   = 1'b0;
  assign m_sel     = SEL_WORD;
  assign m_wdata   = '0;
  assign busy      = state_q != IDLE;
  assign push      = state_q == PUSH && !fifo_full;
  assign pix_valid = !fifo_empty;
  assign pix_data  = fifo_out;
  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (pix_q),
    .pop   (pix_ready),
    .dout  (fifo_out),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: directed scoreboard bench for pixel_fetch with a latency-programmable RAM responder
module tb_pixel_fetch;
  localparam logic [17:0] BASE = 18'h3FFFE;
  localparam int NPIX = 8;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, start = 0, pix_ready = 0, stray = 0;
  logic m_ack = 0;
  logic [15:0] m_rdata = '0;
  logic busy, frame_done, m_req, m_write, pix_valid;
  logic [17:0] m_adr;
  logic [1:0] m_sel;
  logic [15:0] m_wdata;
  logic [23:0] pix_data;
  int checks = 0, passes = 0, lat = 1, cnt = 0, run = 0, fd_count = 0, ack_count = 0;
  logic held = 0;
  logic [17:0] held_adr = '0;
  logic [17:0] exp_adr[$];
  logic [23:0] exp_pix[$];
  pixel_fetch #(.BASE_ADR(BASE), .NUM_PIXELS(NPIX), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .m_adr(m_adr), .m_req(m_req), .m_ack(m_ack), .m_write(m_write), .m_sel(m_sel),
    .m_rdata(m_rdata), .m_wdata(m_wdata), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] ram_rd(input logic [17:0] a);
    case (a)
      18'h3FFFE: return 16'h1122;
      18'h3FFFF: return 16'hAB33;
      18'h00000: return 16'h4455;
      18'h00001: return 16'h0066;
      default:   return {~a[7:0], a[7:0]};
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) begin
      logic [17:0] a;
      logic [15:0] lo, hi;
      a = BASE + 18'(2 * i);
      lo = ram_rd(a);
      hi = ram_rd(a + 18'd1);
      exp_adr.push_back(a);
      exp_adr.push_back(a + 18'd1);
      exp_pix.push_back({lo[15:8], lo[7:0], hi[7:0]});
    end
  endtask
  task automatic pulse_start();
    start = 1;
    tick(1);
    start = 0;
  endtask
  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || exp_pix.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask
  always @(posedge clk) begin
    #1;
    m_ack = 1'b0;
    if (m_req) begin
      if (cnt == lat - 1) begin
        m_ack = 1'b1;
        m_rdata = ram_rd(m_adr);
        cnt = 0;
      end else cnt++;
    end else cnt = 0;
    if (stray) begin
      m_ack = 1'b1;
      m_rdata = 16'hDEAD;
    end
  end
  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (m_req) begin
      if (held) chk("adr_stable", 32'(m_adr), 32'(held_adr));
      held_adr = m_adr;
      held = 1;
      run++;
      if (m_ack) begin
        ack_count++;
        chk("ack_wait", run, lat);
        if (exp_adr.size() == 0) chk("adr_extra", exp_adr.size(), 1);
        else chk("adr", 32'(m_adr), 32'(exp_adr.pop_front()));
        held = 0;
        run = 0;
      end
    end else begin
      held = 0;
      run = 0;
    end
    if (pix_valid && pix_ready) begin
      if (exp_pix.size() == 0) chk("pix_extra", exp_pix.size(), 1);
      else chk("pix", 32'(pix_data), 32'(exp_pix.pop_front()));
    end
  end
  initial begin
    int base_ack, base_fd, n;
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(m_req), 0);
    chk("rst_adr", 32'(m_adr), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_data", 32'(pix_data), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_sel", 32'(m_sel), 32'h3);
    chk("rst_write", 32'(m_write), 0);
    chk("rst_wdata", 32'(m_wdata), 0);
    rst = 0;
    pix_ready = 1;
    tick(2);
    // one-cycle ack, wrapping addresses 3FFFE,3FFFF,0,1,...
    push_frame();
    pulse_start();
    chk("first_req", 32'(m_req), 1);
    chk("first_adr", 32'(m_adr), 32'h3FFFE);
    chk("busy_on", 32'(busy), 1);
    tick(2);
    chk("valid_early", 32'(pix_valid), 0);
    tick(1);
    chk("valid_lat", 32'(pix_valid), 1);
    chk("pix0", 32'(pix_data), 32'h112233);
    wait_idle("frame1_timeout", 200);
    chk("frame1_done", fd_count, 1);
    chk("frame1_adrq", exp_adr.size(), 0);
    chk("frame1_busy", 32'(busy), 0);
    // five-cycle ack latency
    lat = 5;
    push_frame();
    pulse_start();
    wait_idle("frame2_timeout", 400);
    chk("frame2_done", fd_count, 2);
    chk("frame2_acks", ack_count, 32);
    // backpressure: FIFO fills, fetch stalls with m_req low
    lat = 1;
    pix_ready = 0;
    base_ack = ack_count;
    push_frame();
    pulse_start();
    tick(60);
    chk("bp_acks", ack_count - base_ack, 8);
    chk("bp_req_low", 32'(m_req), 0);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_valid", 32'(pix_valid), 1);
    chk("bp_head", 32'(pix_data), 32'(exp_pix[0]));
    tick(3);
    chk("bp_hold", 32'(pix_data), 32'(exp_pix[0]));
    pix_ready = 1;
    wait_idle("frame3_timeout", 200);
    chk("frame3_acks", ack_count - base_ack, 16);
    chk("frame3_done", fd_count, 3);
    // second start mid-frame is ignored
    base_ack = ack_count;
    base_fd = fd_count;
    push_frame();
    pulse_start();
    tick(5);
    pulse_start();
    wait_idle("frame4_timeout", 200);
    tick(5);
    chk("restart_done", fd_count - base_fd, 1);
    chk("restart_acks", ack_count - base_ack, 16);
    chk("restart_req", 32'(m_req), 0);
    // reset while RD_HI request is pending, then stray ack
    lat = 3;
    base_fd = fd_count;
    push_frame();
    pulse_start();
    n = 0;
    while (!(m_req && m_adr == BASE + 18'd1) && n < 50) begin
      tick(1);
      n++;
    end
    chk("rd_hi_reach", 32'(n < 50), 1);
    rst = 1;
    tick(1);
    chk("mid_rst_req", 32'(m_req), 0);
    chk("mid_rst_valid", 32'(pix_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 0;
    exp_adr.delete();
    exp_pix.delete();
    stray = 1;
    tick(1);
    stray = 0;
    tick(3);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_valid", 32'(pix_valid), 0);
    chk("stray_req", 32'(m_req), 0);
    chk("stray_done", fd_count - base_fd, 0);
    // clean frame after recovery
    lat = 2;
    push_frame();
    pulse_start();
    wait_idle("frame5_timeout", 300);
    chk("frame5_done", fd_count - base_fd, 1);
    chk("frame5_adrq", exp_adr.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
